// File: rtl/orbtrace_defs.sv
// orbtrace_defs: shared TPIU framing constants, frame type and extractor state encodings
package orbtrace_defs;
   localparam logic [15:0] TPIU_HALFSYNC   = 16'h7FFF;
   localparam logic [15:0] TPIU_SYNC_HI    = 16'hFFFF;
   localparam int          FRAME_HALFWORDS = 8;
   localparam int          FRAME_BYTES     = 16;
   localparam logic [1:0]  HUNT  = 2'd0;
   localparam logic [1:0]  SKIP  = 2'd1;
   localparam logic [1:0]  FRAME = 2'd2;
   typedef logic [FRAME_HALFWORDS*16-1:0] frame_t;
endpackage

// File: rtl/tpiu_frame_buffer.sv
// tpiu_frame_buffer: two-slot TPIU frame store, written a whole frame at a time, read byte by byte
// ports: wr_en/wr_frame commit a frame (caller guarantees free_cnt != 0); free_cnt counts free
// slots including one released by a last-byte read in this cycle; byte_data/byte_valid/byte_ready
// stream the oldest frame, low byte of half-word 0 first.
module tpiu_frame_buffer
   import orbtrace_defs::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  frame_t     wr_frame,
   output logic [1:0] free_cnt,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready
);
   frame_t     slot [2];
   logic [1:0] slot_v;
   logic       wr_ptr, rd_ptr, pop;
   logic [3:0] byte_idx;
   always_comb begin
      byte_valid = slot_v[rd_ptr];
      byte_data  = byte_valid ? slot[rd_ptr][byte_idx*8 +: 8] : 8'h00;
      pop        = byte_valid && byte_ready && byte_idx == 4'(FRAME_BYTES - 1);
      free_cnt   = 2'd2 - {1'b0, slot_v[0]} - {1'b0, slot_v[1]} + {1'b0, pop};
   end
   always_ff @(posedge clk)
      if (wr_en) slot[wr_ptr] <= wr_frame;
   // a commit into the slot being released in the same cycle must win over the release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         slot_v   <= 2'b00;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         byte_idx <= 4'd0;
      end else begin
         if (byte_valid && byte_ready) byte_idx <= byte_idx + 4'd1;
         if (pop) rd_ptr <= ~rd_ptr;
         if (wr_en) wr_ptr <= ~wr_ptr;
         slot_v <= (slot_v & ~(pop ? (rd_ptr ? 2'b10 : 2'b01) : 2'b00))
                 | (wr_en ? (wr_ptr ? 2'b10 : 2'b01) : 2'b00);
      end
endmodule

// File: rtl/tpiu_frame_extractor.sv
// tpiu_frame_extractor: finds TPIU full-sync in a half-word stream, assembles 16-byte frames, streams them as bytes
// ports: hw_data/hw_valid from the deserializer; byte_data/byte_valid/byte_ready to the UART path;
// synced, frame_pulse and frame_drop drive the LED indications.
module tpiu_frame_extractor
   import orbtrace_defs::*;
#(
   parameter int SYNC_TIMEOUT  = 1024,
   parameter bit DROP_HALFSYNC = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] hw_data,
   input  logic        hw_valid,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        synced,
   output logic        frame_pulse,
   output logic        frame_drop
);
   localparam int TW = SYNC_TIMEOUT > 0 ? $clog2(SYNC_TIMEOUT + 1) : 1;
   logic [1:0]    state;
   logic [15:0]   lh;
   logic          lh_v;
   logic [2:0]    wcnt;
   logic [TW-1:0] tcnt;
   frame_t        asm_q, asm_d;
   logic [1:0]    free_cnt;
   logic          sync_ev, push, done, is_hs, commit, drop, tmo;
   // a half-word is held one strobe in lh so the 0x7FFF of a sync pair never reaches a frame
   always_comb begin
      sync_ev = hw_valid && lh_v && lh == TPIU_HALFSYNC && hw_data == TPIU_SYNC_HI;
      push    = hw_valid && !sync_ev && state == FRAME && lh_v;
      asm_d   = asm_q;
      asm_d[wcnt*16 +: 16] = lh;
      done    = push && wcnt == 3'(FRAME_HALFWORDS - 1);
      is_hs   = DROP_HALFSYNC && asm_d == {FRAME_HALFWORDS{TPIU_HALFSYNC}};
      commit  = done && !is_hs && free_cnt != 2'd0;
      drop    = done && !is_hs && free_cnt == 2'd0;
      // tcnt saturates at SYNC_TIMEOUT so the timeout acts once per loss of sync
      tmo     = hw_valid && !sync_ev && SYNC_TIMEOUT != 0 && tcnt != TW'(SYNC_TIMEOUT)
                && tcnt + 1'b1 == TW'(SYNC_TIMEOUT);
      synced  = state != HUNT;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= HUNT;
         lh          <= 16'h0000;
         lh_v        <= 1'b0;
         wcnt        <= 3'd0;
         tcnt        <= '0;
         asm_q       <= '0;
         frame_pulse <= 1'b0;
         frame_drop  <= 1'b0;
      end else begin
         frame_pulse <= commit;
         frame_drop  <= drop;
         if (sync_ev) begin
            state <= SKIP;
            lh_v  <= 1'b0;
            wcnt  <= 3'd0;
            tcnt  <= '0;
         end else if (hw_valid) begin
            tcnt <= tcnt == TW'(SYNC_TIMEOUT) ? tcnt : tcnt + 1'b1;
            if (state != SKIP || hw_data != TPIU_SYNC_HI) begin
               lh   <= hw_data;
               lh_v <= 1'b1;
            end
            if (state == SKIP && hw_data != TPIU_SYNC_HI) state <= FRAME;
            if (push) begin
               asm_q <= asm_d;
               wcnt  <= wcnt + 3'd1;
            end
            if (tmo) begin
               state <= HUNT;
               lh_v  <= 1'b0;
               wcnt  <= 3'd0;
            end
         end
      end
   tpiu_frame_buffer u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (commit),
      .wr_frame   (asm_d),
      .free_cnt   (free_cnt),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready)
   );
endmodule

// File: tb/tb_tpiu_frame_extractor.sv
// tb_tpiu_frame_extractor: directed test-plan cases plus random traffic against a queue-based frame model
module tb_tpiu_frame_extractor;
   localparam int TMO = 20;
   logic        clk = 1'b0, rst_n = 1'b0, hw_valid = 1'b0, byte_ready = 1'b0;
   logic [15:0] hw_data = 16'h0000;
   logic [7:0]  byte_data;
   logic        byte_valid, synced, frame_pulse, frame_drop;
   int          total = 0, bad = 0, np = 0, nd = 0;
   logic [7:0]  cap [$];
   logic [15:0] pat [8] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
   logic [7:0]  t1 [8] = '{8'h23, 8'h01, 8'h67, 8'h45, 8'hAB, 8'h89, 8'hEF, 8'hCD};
   always #5 clk = ~clk;
   tpiu_frame_extractor #(.SYNC_TIMEOUT(TMO), .DROP_HALFSYNC(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .hw_data(hw_data), .hw_valid(hw_valid), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .synced(synced),
      .frame_pulse(frame_pulse), .frame_drop(frame_drop)
   );
   function automatic void check(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endfunction
   // model: sync flag, pending half-word, words of the frame under assembly, timeout count, bytes not yet read
   bit          m_sync, m_skip, m_lhv, m_pulse, m_drop;
   logic [15:0] m_lh;
   logic [15:0] m_words [$];
   int          m_tcnt;
   logic [7:0]  m_bytes [$];
   task automatic model_strobe(logic [15:0] d);
      bit hs;
      if (m_lhv && m_lh == 16'h7FFF && d == 16'hFFFF) begin
         m_sync = 1; m_skip = 1; m_lhv = 0; m_tcnt = 0;
         m_words.delete();
         return;
      end
      if (m_skip) begin
         if (d != 16'hFFFF) begin m_skip = 0; m_lh = d; m_lhv = 1; end
      end else begin
         if (m_sync && m_lhv) m_words.push_back(m_lh);
         m_lh = d; m_lhv = 1;
      end
      if (m_words.size() == 8) begin
         hs = 1;
         foreach (m_words[i]) if (m_words[i] != 16'h7FFF) hs = 0;
         if (!hs) begin
            if ((m_bytes.size() + 15) / 16 < 2) begin
               foreach (m_words[i]) begin m_bytes.push_back(m_words[i][7:0]); m_bytes.push_back(m_words[i][15:8]); end
               m_pulse = 1;
            end else m_drop = 1;
         end
         m_words.delete();
      end
      if (m_tcnt < TMO) begin
         m_tcnt++;
         if (m_tcnt == TMO) begin m_sync = 0; m_skip = 0; m_lhv = 0; m_words.delete(); end
      end
   endtask
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_sync = 0; m_skip = 0; m_lhv = 0; m_pulse = 0; m_drop = 0; m_tcnt = 0; m_lh = 0;
         m_words.delete(); m_bytes.delete();
      end else begin
         m_pulse = 0; m_drop = 0;
         if (m_bytes.size() != 0 && byte_ready) void'(m_bytes.pop_front());
         if (hw_valid) model_strobe(hw_data);
      end
   end
   initial forever begin
      @(negedge clk);
      check("byte_valid", byte_valid, m_bytes.size() != 0);
      check("byte_data", byte_data, m_bytes.size() != 0 ? m_bytes[0] : 8'h00);
      check("synced", synced, m_sync);
      check("frame_pulse", frame_pulse, m_pulse);
      check("frame_drop", frame_drop, m_drop);
      if (byte_valid && byte_ready) cap.push_back(byte_data);
      if (frame_pulse) np++;
      if (frame_drop) nd++;
   end
   task automatic strobe(logic [15:0] w);
      hw_valid = 1; hw_data = w;
      @(posedge clk); #1;
      hw_valid = 0;
   endtask
   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 0; hw_valid = 0;
      idle(2);
      rst_n = 1;
      cap.delete(); np = 0; nd = 0;
   endtask
   task automatic sync();
      strobe(16'h7FFF); strobe(16'hFFFF);
   endtask
   initial begin
      int r;
      idle(1);
      check("reset_valid", byte_valid, 0);
      check("reset_data", byte_data, 8'h00);
      check("reset_synced", synced, 0);
      do_reset();
      byte_ready = 1;
      sync();
      check("t1_synced", synced, 1);
      foreach (pat[i]) strobe(pat[i]);
      strobe(16'h7FFF);
      idle(20);
      check("t1_len", cap.size(), 16);
      for (int i = 0; i < cap.size() && i < 16; i++) check("t1_byte", cap[i], t1[i % 8]);
      check("t1_pulses", np, 1);
      do_reset();
      foreach (pat[i]) strobe(pat[i]);
      idle(5);
      check("t2_len", cap.size(), 0);
      check("t2_synced", synced, 0);
      do_reset();
      sync();
      strobe(16'h0123); strobe(16'h4567); strobe(16'h89AB);
      strobe(16'h7FFF); strobe(16'hFFFF); strobe(16'hFFFF); strobe(16'hFFFF);
      foreach (pat[i]) strobe(pat[i]);
      strobe(16'h7FFF);
      idle(20);
      check("t3_len", cap.size(), 16);
      for (int i = 0; i < cap.size() && i < 16; i++) check("t3_byte", cap[i], t1[i % 8]);
      check("t3_pulses", np, 1);
      do_reset();
      sync();
      repeat (9) strobe(16'h7FFF);
      idle(5);
      check("t4_len", cap.size(), 0);
      check("t4_pulses", np, 0);
      check("t4_synced", synced, 1);
      do_reset();
      byte_ready = 0;
      sync();
      for (int f = 1; f <= 3; f++) begin
         for (int i = 0; i < 8; i++) strobe({8'(f), 8'(i + 16)});
         if (f < 3) sync();
      end
      idle(2);
      check("t5_drop_before", nd, 0);
      strobe(16'h7FFF);
      idle(2);
      check("t5_drop", nd, 1);
      check("t5_pulses", np, 2);
      byte_ready = 1;
      idle(40);
      check("t5_len", cap.size(), 32);
      for (int i = 0; i < cap.size() && i < 32; i++)
         check("t5_byte", cap[i], i % 2 == 0 ? 8'((i % 16) / 2 + 16) : 8'(i / 16 + 1));
      do_reset();
      byte_ready = 0;
      sync();
      for (int i = 0; i < 20; i++) begin
         strobe(16'(16'h1000 + i));
         if (i == 18) check("t6_synced_19", synced, 1);
      end
      check("t6_synced_20", synced, 0);
      idle(2);
      check("t6_pulses", np, 2);
      check("t6_valid_held", byte_valid, 1);
      strobe(16'h2222); strobe(16'h3333);
      #2 rst_n = 0;
      #1;
      check("t6_rst_valid", byte_valid, 0);
      check("t6_rst_data", byte_data, 8'h00);
      check("t6_rst_synced", synced, 0);
      idle(2);
      rst_n = 1;
      for (int c = 0; c < 4000; c++) begin
         hw_valid = $urandom_range(0, 9) < 7;
         r = $urandom_range(0, 9);
         hw_data = r < 3 ? 16'h7FFF : r < 5 ? 16'hFFFF : 16'($urandom);
         byte_ready = $urandom_range(0, 9) < (c % 1000 < 500 ? 8 : 2);
         @(posedge clk); #1;
      end
      hw_valid = 0; byte_ready = 1;
      idle(40);
      check("final_empty", byte_valid, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
